alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one combinational 32-bit `alu` (ops: add, sub, and, or, xor) between NREQ requesters.
- Each requester issues an operation over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. The result is captured in a single output register and returned with the requester ID over a valid/ready response channel.
- Sits between issue logic and the shared ALU in the RISC-V execute path.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 32, operand/result width; must match the `alu` datapath.
- IDW, 3, width of resp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  bit i = requester i has an operation pending.
- req_ready  out  NREQ  bit i = requester i's operation is accepted this cycle (one-hot or zero).
- req_a  in  NREQ*WIDTH  operand A; requester i uses [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- req_sel  in  NREQ*3  opcode; requester i uses [i*3 +: 3].
- resp_valid  out  1  output register holds a result.
- resp_ready  in  1  consumer accepts the result.
- resp_y  out  WIDTH  registered result.
- resp_id  out  IDW  index of the requester that produced resp_y.
- resp_err  out  1  opcode was illegal (101..111).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - resp_valid=0, resp_y=0, resp_id=0, resp_err=0, rr_ptr=0, state=EMPTY.
  - req_ready=0 while rst_n=0.
  - Any in-flight result is discarded and is not replayed after reset.
- States:
  - EMPTY: output register free.
  - FULL: resp_valid=1, result held.
- can_accept = (state==EMPTY) || (resp_ready && resp_valid).
- Arbitration (combinational):
  - When can_accept, scan req_valid starting at index rr_ptr, wrapping modulo NREQ. The first set bit is the grant g.
  - req_ready[g]=1; all other bits are 0. If no request is valid, req_ready=0.
- On a grant:
  - Operands of requester g drive the `alu`.
  - At the next rising edge: resp_y<=alu y, resp_id<=g, resp_err<=(sel>3'b100), state<=FULL, rr_ptr<=(g+1) mod NREQ.
- Illegal opcode: resp_y=0 and resp_err=1. The request is still consumed and still advances rr_ptr.
- Latency: exactly 1 cycle from the accepting edge to resp_valid=1.
- Throughput: 1 op/cycle while resp_ready stays high. A simultaneous drain and new grant in the same cycle keeps state=FULL with the new result; no bubble.
- Drain with no new grant: FULL -> EMPTY, resp_valid<=0. resp_y/resp_id/resp_err hold their last values.
- Backpressure: FULL with resp_ready=0 gives req_ready=0. Outputs are stable and must not change while resp_valid=1 and resp_ready=0.
- Arithmetic:
  - add/sub wrap modulo 2**WIDTH; no carry or overflow flags.
  - sub = a - b.
  - and/or/xor are bitwise.
- rr_ptr is unchanged in cycles without a grant.
- Starvation bound: a requester holding req_valid=1 is granted within NREQ accepting cycles.
- Requesters must hold req_a/req_b/req_sel stable while req_valid=1 and req_ready=0. The block does not check this.

Decomposition:
- Package alu_pkg:
  - Opcode localparams OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_XOR=3'b100.
  - State encoding ST_EMPTY=1'b0, ST_FULL=1'b1.
- Sub-module rr_arbiter #(NREQ), combinational:
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant, binary grant index, any_grant.
- alu_arbiter instantiates one rr_arbiter and one existing `alu`.
- It also owns rr_ptr, the state flop and the output register.

Test Plan:
- Single op: req0 a=15 b=5 sel=000, resp_ready=1 -> req_ready=01 in the same cycle; next cycle resp_valid=1, resp_y=20, resp_id=0, resp_err=0.
- Contention: both requesters valid from reset, req0 sub 15-7, req1 and FFFF0000&00FF00FF -> grants 0 then 1 back-to-back. Responses: y=8 id=0, then y=00FF0000 id=1. Alternation continues while both are held.
- Backpressure: req1 or AAAA0000|55550000, resp_ready=0 for 3 cycles -> resp_y=FFFF0000 held stable and req_ready=00 throughout. When resp_ready rises, the pending req0 xor FFFFFFFF^0000FFFF is accepted in the same cycle and appears next cycle as FFFF0000, id=0.
- Wrap and illegal: sub a=0 b=1 -> y=FFFFFFFF. sel=3'b111 -> y=0, resp_err=1, and rr_ptr still advances.
- Reset mid-operation: assert rst_n=0 while resp_valid=1 and resp_ready=0 -> resp_valid=0 immediately (asynchronous); after release, first grant goes to req0 when both are valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes and output-register states.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, sub, and, or, xor; illegal opcodes yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_sel,
    output logic [WIDTH-1:0] o_y
);

    // Opcode decode; add/sub wrap modulo 2**WIDTH.
    always_comb begin
        o_y = '0;
        case (i_sel)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after i_ptr wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_gnt_idx,
    output logic            o_any
);

    // Scan requests from i_ptr with wrap-around and keep the first hit.
    always_comb begin
        logic [31:0] w_idx;
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_idx     = '0;
        if (i_en) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                w_idx = (32'(i_ptr) + k) % NREQ;
                if (!o_any && i_req[w_idx[PW-1:0]]) begin
                    o_any                  = 1'b1;
                    o_gnt[w_idx[PW-1:0]]   = 1'b1;
                    o_gnt_idx              = w_idx[PW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters with a single registered response slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32,
    parameter int IDW   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_sel,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_y,
    output logic [IDW-1:0]        resp_id,
    output logic                  resp_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_rr_ptr;
    logic [WIDTH-1:0] r_resp_y;
    logic [IDW-1:0]   r_resp_id;
    logic             r_resp_err;

    logic             w_can_accept;
    logic             w_en;
    logic [NREQ-1:0]  w_gnt;
    logic [PW-1:0]    w_gnt_idx;
    logic             w_any;
    logic [PW-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_sel;
    logic [WIDTH-1:0] w_y;

    // The slot is free when empty or when its result drains this cycle; nothing is accepted in reset.
    assign w_can_accept = (r_state == ST_EMPTY) || (resp_ready && resp_valid);
    assign w_en         = w_can_accept && rst_n;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .i_en      (w_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    assign req_ready = w_gnt;

    // Route the granted requester's operands to the shared ALU.
    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == PW'(i)) begin
                w_a   = req_a[i*WIDTH +: WIDTH];
                w_b   = req_b[i*WIDTH +: WIDTH];
                w_sel = req_sel[i*3 +: 3];
            end
        end
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a   (w_a),
        .i_b   (w_b),
        .i_sel (w_sel),
        .o_y   (w_y)
    );

    assign w_ptr_nxt = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Output-slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // A grant always refills the slot; a drain without a grant empties it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_any)
            w_state_nxt = ST_FULL;
        else if (r_state == ST_FULL && resp_ready)
            w_state_nxt = ST_EMPTY;
    end

    // Capture the result and advance the round-robin pointer on each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_resp_y   <= '0;
            r_resp_id  <= '0;
            r_resp_err <= 1'b0;
        end else if (w_any) begin
            r_rr_ptr   <= w_ptr_nxt;
            r_resp_y   <= w_y;
            r_resp_id  <= IDW'(w_gnt_idx);
            r_resp_err <= (w_sel > OP_XOR);
        end
    end

    assign resp_valid = (r_state == ST_FULL);
    assign resp_y     = r_resp_y;
    assign resp_id    = r_resp_id;
    assign resp_err   = r_resp_err;

endmodule
